// File: rtl/clb_cfg_defs.sv
// Shared definitions for the CLB configuration loader: FSM encoding,
// default sync word and constant helpers for deriving beat/counter sizes.
package clb_cfg_defs;

  typedef enum logic [2:0] {
    ST_HUNT   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hA5;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 32'd1) / b;
  endfunction

  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r = r + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cfg_beat_assembler.sv
// Frame assembly buffer (indexed beat writes, LSB beat first) and XOR
// accumulator over full beats; padding above CFG_WIDTH is never stored.
module cfg_beat_assembler #(
  parameter int unsigned CFG_WIDTH = 36,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned NBEATS    = 5,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_we,
  input  logic [CNT_W-1:0]     i_idx,
  input  logic [WORD_W-1:0]    i_data,
  output logic [CFG_WIDTH-1:0] o_frame,
  output logic [WORD_W-1:0]    o_acc
);

  logic [CFG_WIDTH-1:0] w_buf;
  logic [WORD_W-1:0]    r_acc;

  // One slice per beat; the last slice keeps only the in-frame bits.
  for (genvar k = 0; k < NBEATS; k++) begin : g_slice
    localparam int unsigned LO = k * WORD_W;
    localparam int unsigned SW = ((CFG_WIDTH - LO) < WORD_W) ? (CFG_WIDTH - LO) : WORD_W;

    logic [SW-1:0] r_slice;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_slice <= '0;
      end else if (i_clr) begin
        r_slice <= '0;
      end else if (i_we && (i_idx == CNT_W'(k))) begin
        r_slice <= i_data[SW-1:0];
      end
    end

    assign w_buf[LO +: SW] = r_slice;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_we) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_frame = w_buf;
  assign o_acc   = r_acc;

endmodule

// File: rtl/clb_config_loader.sv
// CLB configuration writer: hunts for a sync beat, assembles a frame,
// verifies its XOR checksum and commits it to the tile with a one-cycle cen.
module clb_config_loader
  import clb_cfg_defs::*;
#(
  parameter int unsigned       CFG_WIDTH = 36,
  parameter int unsigned       WORD_W    = 8,
  parameter logic [WORD_W-1:0] SYNC_WORD = WORD_W'(DEFAULT_SYNC_WORD)
) (
  input  logic                 cclk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [CFG_WIDTH-1:0] cfg_out,
  output logic                 cen,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned NBEATS = ceil_div(CFG_WIDTH, WORD_W);
  localparam int unsigned CNT_W  = clog2_u(NBEATS + 32'd1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_asm_clr;
  logic                 w_asm_we;
  logic                 w_commit;
  logic                 w_fail;
  logic [CFG_WIDTH-1:0] w_frame;
  logic [WORD_W-1:0]    w_acc;
  logic [CFG_WIDTH-1:0] r_cfg_out;
  logic                 r_cen;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;

  assign w_ready  = ((r_state == ST_HUNT) || (r_state == ST_LOAD) || (r_state == ST_CHECK))
                    && !clear && !rst;
  assign w_accept = in_valid && w_ready;

  cfg_beat_assembler #(
    .CFG_WIDTH (CFG_WIDTH),
    .WORD_W    (WORD_W),
    .NBEATS    (NBEATS),
    .CNT_W     (CNT_W)
  ) u_asm (
    .clk     (cclk),
    .rst     (rst),
    .i_clr   (w_asm_clr),
    .i_we    (w_asm_we),
    .i_idx   (r_cnt),
    .i_data  (in_data),
    .o_frame (w_frame),
    .o_acc   (w_acc)
  );

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_state <= ST_HUNT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and datapath strobes; clear overrides every state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_asm_clr   = 1'b0;
    w_asm_we    = 1'b0;
    w_commit    = 1'b0;
    w_fail      = 1'b0;
    if (clear) begin
      w_state_nxt = ST_HUNT;
      w_cnt_nxt   = '0;
      w_asm_clr   = 1'b1;
    end else begin
      case (r_state)
        ST_HUNT: begin
          if (w_accept && (in_data == SYNC_WORD)) begin
            w_state_nxt = ST_LOAD;
            w_cnt_nxt   = '0;
            w_asm_clr   = 1'b1;
          end
        end
        ST_LOAD: begin
          if (w_accept) begin
            w_asm_we  = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(NBEATS - 32'd1)) begin
              w_state_nxt = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (w_accept) begin
            if (in_data == w_acc) begin
              w_state_nxt = ST_COMMIT;
              w_commit    = 1'b1;
            end else begin
              w_state_nxt = ST_ERROR;
              w_fail      = 1'b1;
            end
          end
        end
        ST_COMMIT: w_state_nxt = ST_DONE;
        ST_DONE:   w_state_nxt = ST_DONE;
        ST_ERROR:  w_state_nxt = ST_ERROR;
        default:   w_state_nxt = ST_HUNT;
      endcase
    end
  end

  // Output registers; cfg_out only moves on the commit edge.
  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_cfg_out <= '0;
      r_cen     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_cen  <= w_commit;
      r_busy <= (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_CHECK) ||
                (w_state_nxt == ST_COMMIT);
      if (w_commit) begin
        r_cfg_out <= w_frame;
      end
      if (clear) begin
        r_done  <= 1'b0;
        r_error <= 1'b0;
      end else begin
        if (r_state == ST_COMMIT) begin
          r_done <= 1'b1;
        end
        if (w_fail) begin
          r_error <= 1'b1;
        end
      end
    end
  end

  assign in_ready = w_ready;
  assign cfg_out  = r_cfg_out;
  assign cen      = r_cen;
  assign busy     = r_busy;
  assign done     = r_done;
  assign error    = r_error;

endmodule

// File: tb/tb_clb_config_loader.sv
// Scoreboard bench for clb_config_loader: stimulus pushes expected commits,
// a negedge monitor pops them whenever cen is seen.
module tb_clb_config_loader;

  typedef struct {
    logic [35:0] cfg;
    int          cyc;
  } exp_t;

  typedef logic [7:0] frame_t [7];

  logic        cclk = 1'b0;
  logic        rst;
  logic        clear;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [35:0] cfg_out;
  logic        cen;
  logic        busy;
  logic        done;
  logic        error;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic prev_cen = 1'b0;
  exp_t sb[$];

  clb_config_loader #(
    .CFG_WIDTH (36),
    .WORD_W    (8),
    .SYNC_WORD (8'hA5)
  ) dut (
    .cclk     (cclk),
    .rst      (rst),
    .clear    (clear),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .cfg_out  (cfg_out),
    .cen      (cen),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 cclk = ~cclk;

  always @(posedge cclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cen pulse must match the oldest expected commit.
  always @(negedge cclk) begin
    exp_t e;
    if (cen === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_cen: got cen=1 at cycle %0d, expected no commit", cyc);
      end else begin
        e = sb.pop_front();
        chk("commit_cfg_out", 64'(cfg_out), 64'(e.cfg));
        chk("commit_cycle", 64'(cyc), 64'(e.cyc));
      end
      chk("cen_single_cycle", 64'(prev_cen), 64'(0));
    end
    prev_cen = cen;
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input int idle, output int acc_edge);
    int n;
    repeat (idle) @(negedge cclk);
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge cclk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: in_ready stayed %b, required 1 for beat %0h", in_ready, d);
    end
    acc_edge = cyc + 1;
    @(negedge cclk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input frame_t b, input int idle, input logic expect_commit,
                            input logic [35:0] exp_cfg);
    int e;
    e = 0;
    for (int i = 0; i < 7; i++) send_beat(b[i], idle, e);
    if (expect_commit) sb.push_back('{cfg: exp_cfg, cyc: e});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("in_ready_low_during_clear", 64'(in_ready), 64'(0));
    @(negedge cclk);
    clear = 1'b0;
    #1;
    chk("done_after_clear", 64'(done), 64'(0));
    chk("error_after_clear", 64'(error), 64'(0));
    chk("in_ready_after_clear", 64'(in_ready), 64'(1));
  endtask

  task automatic post_commit(input string tag);
    chk({tag, "_in_ready_commit"}, 64'(in_ready), 64'(0));
    chk({tag, "_busy_commit"}, 64'(busy), 64'(1));
    chk({tag, "_done_commit"}, 64'(done), 64'(0));
    @(negedge cclk);
    @(negedge cclk);
    chk({tag, "_cen_after"}, 64'(cen), 64'(0));
    chk({tag, "_done_after"}, 64'(done), 64'(1));
    chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    chk({tag, "_in_ready_after"}, 64'(in_ready), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    frame_t nominal;
    frame_t bad;
    frame_t fresh;
    frame_t padded;
    int     e;
    logic [7:0] junk [3];

    nominal = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h41};
    bad     = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h05, 8'h40};
    fresh   = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    padded  = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'hF5, 8'hB1};
    junk    = '{8'h00, 8'hFF, 8'hA4};

    rst      = 1'b1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #2;
    chk("rst_cfg_out", 64'(cfg_out), 64'(0));
    chk("rst_cen", 64'(cen), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_error", 64'(error), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    repeat (2) @(negedge cclk);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 64'(in_ready), 64'(1));

    // Nominal back-to-back frame.
    send_frame(nominal, 0, 1'b1, 36'h544332211);
    post_commit("nominal");

    // Sync hunt: non-sync beats are swallowed while staying in HUNT.
    do_clear();
    for (int i = 0; i < 3; i++) begin
      send_beat(junk[i], 0, e);
      chk("hunt_in_ready", 64'(in_ready), 64'(1));
      chk("hunt_busy", 64'(busy), 64'(0));
    end
    send_frame(nominal, 0, 1'b1, 36'h544332211);
    post_commit("hunt");

    // Bad checksum.
    do_clear();
    send_frame(bad, 0, 1'b0, 36'h0);
    chk("bad_error", 64'(error), 64'(1));
    chk("bad_in_ready", 64'(in_ready), 64'(0));
    chk("bad_done", 64'(done), 64'(0));
    repeat (3) @(negedge cclk);
    chk("bad_cfg_out_kept", 64'(cfg_out), 64'(36'h544332211));
    chk("bad_error_sticky", 64'(error), 64'(1));
    do_clear();

    // Abort mid-frame, then a complete new frame.
    send_beat(8'hA5, 0, e);
    send_beat(8'h11, 0, e);
    send_beat(8'h22, 0, e);
    send_beat(8'h33, 0, e);
    chk("abort_busy_mid", 64'(busy), 64'(1));
    do_clear();
    chk("abort_cfg_out_kept", 64'(cfg_out), 64'(36'h544332211));
    send_frame(fresh, 0, 1'b1, 36'h000000001);
    post_commit("abort");
    chk("abort_cfg_out_new", 64'(cfg_out), 64'(36'h000000001));

    // Stalls between beats and padding bits in the last payload beat.
    do_clear();
    send_frame(padded, 3, 1'b1, 36'h544332211);
    post_commit("stall");

    // Asynchronous reset between edges in the middle of LOAD.
    do_clear();
    send_beat(8'hA5, 0, e);
    send_beat(8'h11, 0, e);
    send_beat(8'h22, 0, e);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_cfg_out", 64'(cfg_out), 64'(0));
    chk("arst_cen", 64'(cen), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_in_ready", 64'(in_ready), 64'(0));
    @(negedge cclk);
    rst = 1'b0;
    #1;
    chk("arst_release_in_ready", 64'(in_ready), 64'(1));
    chk("arst_release_busy", 64'(busy), 64'(0));
    @(negedge cclk);
    send_frame(nominal, 0, 1'b1, 36'h544332211);
    post_commit("recover");

    repeat (2) @(negedge cclk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
